cluster_credit_dispatcher: RTL and testbench
============================================

Name: cluster_credit_dispatcher

Overview:
- Sits between the packet scheduler and the per-cluster task schedulers.
- Tracks two credit pools per cluster: free HER slots and free L1 packet-buffer bytes. A task is only ever forwarded to a cluster that can store it.
- Each incoming task goes to its home cluster when that cluster is eligible, otherwise to the next eligible cluster in round-robin order.
- Cluster feedback returns credits.

Parameters:
- NUM_CLUSTERS, 4, number of clusters served (power of 2, ≥2)
- NUM_HERS_PER_CLUSTER, 64, max outstanding tasks per cluster
- L1_PKT_BUFF_SIZE, 512, L1 packet-buffer bytes per cluster
- SLOT_SIZE, 64, allocation granule in bytes (power of 2)
- PKT_SIZE_W, 32, width of packet-size fields

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- task_valid_i  in  1  incoming task valid
- task_ready_o  out  1  incoming task accepted
- task_size_i  in  PKT_SIZE_W  packet bytes
- task_home_i  in  $clog2(NUM_CLUSTERS)  preferred cluster
- disp_valid_o  out  1  dispatched task valid
- disp_ready_i  in  1  target cluster accepted the task
- disp_cluster_o  out  $clog2(NUM_CLUSTERS)  target cluster
- disp_size_o  out  PKT_SIZE_W  packet bytes, passed through unchanged
- fb_valid_i  in  1  feedback (task completed) valid
- fb_ready_o  out  1  feedback accepted, constant 1
- fb_cluster_i  in  $clog2(NUM_CLUSTERS)  cluster returning credits
- fb_size_i  in  PKT_SIZE_W  bytes of the completed task
- err_o  out  1  sticky error flag
- stat_dispatch_o  out  NUM_CLUSTERS*32  per-cluster dispatch counters (see Optional Feature)

Behaviour:
- **Reset values:**
  - Outputs: task_ready_o=0, disp_valid_o=0, disp_cluster_o=0, disp_size_o=0, err_o=0, stat_dispatch_o=0.
  - State: her_cnt[c]=0, byte_free[c]=L1_PKT_BUFF_SIZE, rr_q=0, output register empty.
  - Reset asserted mid-operation discards any pending output and restores all credits.
- **Rounded size:** rsz = task_size_i rounded up to a multiple of SLOT_SIZE, computed at PKT_SIZE_W+1 bits. Size 0 gives rsz=0. The same rounding applies to fb_size_i.
- **Eligibility:** cluster c is eligible iff her_cnt[c] < NUM_HERS_PER_CLUSTER && byte_free[c] >= rsz. Eligibility uses registered counters only. Credits returned this cycle become visible next cycle.
- **Selection (combinational):**
  - If task_home_i is eligible, pick it.
  - Otherwise pick the first eligible cluster scanning rr_q, rr_q+1, … modulo NUM_CLUSTERS.
  - none_elig = no cluster is eligible.
- **Output register:** single entry. It is free when empty, or when disp_valid_o && disp_ready_i this cycle (full throughput, one task per cycle).
- **task_ready_o:**
  - 1 when the output register is free AND (a cluster is eligible OR rsz > L1_PKT_BUFF_SIZE).
  - Combinational from task_size_i, task_home_i and registered state. It does not depend on task_valid_i.
- **Accept** (task_valid_i && task_ready_o) with a legal size:
  - Load disp_cluster_o/disp_size_o and set disp_valid_o on the next edge. Latency is 1 cycle.
  - Increment her_cnt[sel] and subtract rsz from byte_free[sel].
  - If sel ≠ task_home_i, set rr_q ← sel+1 (wraps). A home dispatch leaves rr_q unchanged.
- **Oversize task** (rsz > L1_PKT_BUFF_SIZE): accepted and dropped. No dispatch, no credit change, err_o←1.
- **Output hold:** disp_valid_o and its payload stay stable until disp_ready_i. Credits are debited at accept, not at the downstream handshake.
- **Feedback:** when fb_valid_i, decrement her_cnt[fb_cluster_i] and add rsz(fb_size_i) to byte_free[fb_cluster_i].
  - A debit and a credit on the same cluster in the same cycle apply net.
  - Underflow (her_cnt=0) or overflow (byte_free+rsz > L1_PKT_BUFF_SIZE) leaves the counters unchanged and sets err_o←1.
- **Counter widths:**
  - her_cnt: $clog2(NUM_HERS_PER_CLUSTER)+1 bits.
  - byte_free: $clog2(L1_PKT_BUFF_SIZE)+1 bits.
- err_o clears only on reset.

Optional Feature:
- Macro: CLUSTER_DISPATCH_STATS_EN.
- **Defined:** stat_dispatch_o[c*32 +: 32] counts accepted dispatches to cluster c. Each counter increments on the accept edge and saturates at 32'hFFFF_FFFF.
- **Undefined:** stat_dispatch_o is tied to 0 and no counters are synthesized.

Test Plan:
- **Home dispatch:** after reset, task size=100 home=2 → next cycle disp_valid_o=1, disp_cluster_o=2, disp_size_o=100; byte_free[2]=384, her_cnt[2]=1; rr_q stays 0.
- **Byte exhaustion and fallback:** 4 tasks size=128 home=1 with disp_ready_i=1 → all go to cluster 1, byte_free[1]=0. 5th task size=1 home=1 → dispatched to cluster 0 with rr_q=0, and rr_q becomes 1.
- **HER limit and fill:** NUM_HERS_PER_CLUSTER=2, NUM_CLUSTERS=2, size=0 tasks:
  - First 4 tasks are dispatched.
  - 5th task: task_ready_o=0.
  - fb_valid_i with cluster=1, size=0 → task_ready_o=1 the following cycle, and the task goes to cluster 1.
- **Backpressure:** disp_ready_i=0 for 5 cycles → disp_valid_o, disp_cluster_o and disp_size_o stable; task_ready_o=0. Release → handshake completes, and a new task is accepted in the same cycle.
- **Simultaneous events and errors:**
  - Accept to cluster 0 (size=64) together with feedback for cluster 0 (size=64) → byte_free[0] unchanged.
  - Task size=600 → dropped, no disp_valid_o, err_o=1.
  - Feedback to an idle cluster → err_o=1, counters unchanged.
- **Stats:** with CLUSTER_DISPATCH_STATS_EN, 3 dispatches to cluster 3 → stat_dispatch_o[127:96]=3. Without the macro, the same stimulus leaves stat_dispatch_o=0.

Source files
------------

// File: rtl/cluster_credit_dispatcher.sv
// rtl/cluster_credit_dispatcher.sv - credit-gated task dispatcher across clusters
// Optional per-cluster dispatch counters enabled by CLUSTER_DISPATCH_STATS_EN.
module cluster_credit_dispatcher #(
  parameter int unsigned NUM_CLUSTERS         = 4,
  parameter int unsigned NUM_HERS_PER_CLUSTER = 64,
  parameter int unsigned L1_PKT_BUFF_SIZE     = 512,
  parameter int unsigned SLOT_SIZE            = 64,
  parameter int unsigned PKT_SIZE_W           = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            task_valid_i,
  output logic                            task_ready_o,
  input  logic [PKT_SIZE_W-1:0]           task_size_i,
  input  logic [$clog2(NUM_CLUSTERS)-1:0] task_home_i,
  output logic                            disp_valid_o,
  input  logic                            disp_ready_i,
  output logic [$clog2(NUM_CLUSTERS)-1:0] disp_cluster_o,
  output logic [PKT_SIZE_W-1:0]           disp_size_o,
  input  logic                            fb_valid_i,
  output logic                            fb_ready_o,
  input  logic [$clog2(NUM_CLUSTERS)-1:0] fb_cluster_i,
  input  logic [PKT_SIZE_W-1:0]           fb_size_i,
  output logic                            err_o,
  output logic [NUM_CLUSTERS*32-1:0]      stat_dispatch_o
);

  localparam int unsigned CW = $clog2(NUM_CLUSTERS);
  localparam int unsigned HW = $clog2(NUM_HERS_PER_CLUSTER) + 1;
  localparam int unsigned BW = $clog2(L1_PKT_BUFF_SIZE) + 1;
  localparam int unsigned RW = PKT_SIZE_W + 1;
  localparam logic [RW-1:0] SLOT_MASK = ~RW'(SLOT_SIZE - 1);
  localparam logic [RW-1:0] L1_SIZE   = RW'(L1_PKT_BUFF_SIZE);
  localparam logic [HW-1:0] HER_MAX   = HW'(NUM_HERS_PER_CLUSTER);

  // One extra bit so a size near 2^PKT_SIZE_W still rounds up without wrapping.
  function automatic logic [RW-1:0] round_up(input logic [PKT_SIZE_W-1:0] s);
    return ({1'b0, s} + RW'(SLOT_SIZE - 1)) & SLOT_MASK;
  endfunction

  logic [HW-1:0]         her_cnt_q   [NUM_CLUSTERS];
  logic [HW-1:0]         her_cnt_d   [NUM_CLUSTERS];
  logic [BW-1:0]         byte_free_q [NUM_CLUSTERS];
  logic [BW-1:0]         byte_free_d [NUM_CLUSTERS];
  logic [CW-1:0]         rr_q, rr_d;
  logic                  disp_valid_q, disp_valid_d;
  logic [CW-1:0]         disp_cluster_q, disp_cluster_d;
  logic [PKT_SIZE_W-1:0] disp_size_q, disp_size_d;
  logic                  err_q, err_d;

  logic [RW-1:0]           task_rsz, fb_rsz;
  logic                    oversize;
  logic [NUM_CLUSTERS-1:0] elig;
  logic                    any_elig;
  logic [CW-1:0]           sel, scan_idx;
  logic                    found;
  logic                    out_free, accept, accept_ok, fb_ok;

  always_comb begin
    task_rsz = round_up(task_size_i);
    fb_rsz   = round_up(fb_size_i);
    oversize = task_rsz > L1_SIZE;
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      elig[c] = (her_cnt_q[c] < HER_MAX) && (RW'(byte_free_q[c]) >= task_rsz);
    end
  end

  // Home first, then round-robin scan starting at rr_q.
  always_comb begin
    sel      = task_home_i;
    found    = elig[task_home_i];
    scan_idx = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      scan_idx = rr_q + CW'(i);
      if (!found && elig[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign any_elig     = |elig;
  assign out_free     = !disp_valid_q || disp_ready_i;
  assign task_ready_o = rst_ni && out_free && (any_elig || oversize);
  assign accept       = task_valid_i && task_ready_o;
  assign accept_ok    = accept && !oversize;
  assign fb_ok        = fb_valid_i && (her_cnt_q[fb_cluster_i] != '0) &&
                        (RW'(byte_free_q[fb_cluster_i]) + fb_rsz <= L1_SIZE);

  // Debit and credit on the same cluster combine into a single net update.
  always_comb begin
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      her_cnt_d[c]   = her_cnt_q[c];
      byte_free_d[c] = byte_free_q[c];
      if (accept_ok && sel == CW'(c)) begin
        her_cnt_d[c]   = her_cnt_d[c] + HW'(1);
        byte_free_d[c] = byte_free_d[c] - BW'(task_rsz);
      end
      if (fb_ok && fb_cluster_i == CW'(c)) begin
        her_cnt_d[c]   = her_cnt_d[c] - HW'(1);
        byte_free_d[c] = byte_free_d[c] + BW'(fb_rsz);
      end
    end
  end

  always_comb begin
    disp_valid_d   = disp_valid_q;
    disp_cluster_d = disp_cluster_q;
    disp_size_d    = disp_size_q;
    rr_d           = rr_q;
    err_d          = err_q | (accept && oversize) | (fb_valid_i && !fb_ok);
    if (disp_valid_q && disp_ready_i) begin
      disp_valid_d = 1'b0;
    end
    if (accept_ok) begin
      disp_valid_d   = 1'b1;
      disp_cluster_d = sel;
      disp_size_d    = task_size_i;
      if (sel != task_home_i) begin
        rr_d = sel + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        her_cnt_q[c]   <= '0;
        byte_free_q[c] <= BW'(L1_PKT_BUFF_SIZE);
      end
      rr_q           <= '0;
      disp_valid_q   <= 1'b0;
      disp_cluster_q <= '0;
      disp_size_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      her_cnt_q      <= her_cnt_d;
      byte_free_q    <= byte_free_d;
      rr_q           <= rr_d;
      disp_valid_q   <= disp_valid_d;
      disp_cluster_q <= disp_cluster_d;
      disp_size_q    <= disp_size_d;
      err_q          <= err_d;
    end
  end

  assign disp_valid_o   = disp_valid_q;
  assign disp_cluster_o = disp_cluster_q;
  assign disp_size_o    = disp_size_q;
  assign err_o          = err_q;
  assign fb_ready_o     = 1'b1;

`ifdef CLUSTER_DISPATCH_STATS_EN
  logic [31:0] stat_q [NUM_CLUSTERS];
  logic [31:0] stat_d [NUM_CLUSTERS];

  always_comb begin
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      stat_d[c] = stat_q[c];
      if (accept_ok && sel == CW'(c) && stat_q[c] != 32'hFFFF_FFFF) begin
        stat_d[c] = stat_q[c] + 32'd1;
      end
      stat_dispatch_o[c*32 +: 32] = stat_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        stat_q[c] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end
`else
  assign stat_dispatch_o = '0;
`endif

endmodule

// File: tb/tb_cluster_credit_dispatcher.sv
// tb/tb_cluster_credit_dispatcher.sv - randomized bench for cluster_credit_dispatcher
// Stats expectations follow CLUSTER_DISPATCH_STATS_EN.
module tb_cluster_credit_dispatcher;
  localparam int NC = 4;
  localparam int NH = 64;
  localparam int L1 = 512;
  localparam int SL = 64;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         task_valid_i, task_ready_o;
  logic [31:0]  task_size_i;
  logic [1:0]   task_home_i;
  logic         disp_valid_o, disp_ready_i;
  logic [1:0]   disp_cluster_o;
  logic [31:0]  disp_size_o;
  logic         fb_valid_i, fb_ready_o;
  logic [1:0]   fb_cluster_i;
  logic [31:0]  fb_size_i;
  logic         err_o;
  logic [127:0] stat_dispatch_o;

  cluster_credit_dispatcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .task_size_i(task_size_i), .task_home_i(task_home_i),
    .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
    .disp_cluster_o(disp_cluster_o), .disp_size_o(disp_size_o),
    .fb_valid_i(fb_valid_i), .fb_ready_o(fb_ready_o),
    .fb_cluster_i(fb_cluster_i), .fb_size_i(fb_size_i),
    .err_o(err_o), .stat_dispatch_o(stat_dispatch_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  int         m_her   [NC];
  longint     m_bytes [NC];
  longint     m_stat  [NC];
  int         m_rr;
  bit         m_valid;
  int         m_cl;
  logic [31:0] m_sz;
  bit         m_err;
  typedef struct { int cl; logic [31:0] sz; } job_t;
  job_t outstanding[$];

  function automatic longint rnd(input logic [31:0] s);
    return ((longint'(s) + SL - 1) / SL) * SL;
  endfunction

  function automatic bit elig(input int c, input longint r);
    return m_her[c] < NH && m_bytes[c] >= r;
  endfunction

  function automatic int pick(input longint r, input int home);
    if (elig(home, r)) return home;
    for (int k = 0; k < NC; k++) if (elig((m_rr + k) % NC, r)) return (m_rr + k) % NC;
    return -1;
  endfunction

  function automatic bit m_ready();
    longint r = rnd(task_size_i);
    return (!m_valid || disp_ready_i) && (pick(r, int'(task_home_i)) >= 0 || r > L1);
  endfunction

  function automatic logic [127:0] exp_stat();
    logic [127:0] v = '0;
`ifdef CLUSTER_DISPATCH_STATS_EN
    for (int c = 0; c < NC; c++) v[c*32 +: 32] = 32'(m_stat[c]);
`endif
    return v;
  endfunction

  task automatic model_step();
    longint r     = rnd(task_size_i);
    longint fr    = rnd(fb_size_i);
    bit     rdy   = m_ready();
    int     sel   = pick(r, int'(task_home_i));
    int     fc    = int'(fb_cluster_i);
    bit     fb_ok = fb_valid_i && m_her[fc] > 0 && m_bytes[fc] + fr <= L1;
    if (fb_valid_i && !fb_ok) m_err = 1;
    if (m_valid && disp_ready_i) m_valid = 0;
    if (task_valid_i && rdy) begin
      if (r > L1) m_err = 1;
      else begin
        m_her[sel]++;
        m_bytes[sel] -= r;
        m_valid = 1;
        m_cl = sel;
        m_sz = task_size_i;
        if (m_stat[sel] < 64'hFFFF_FFFF) m_stat[sel]++;
        if (sel != int'(task_home_i)) m_rr = (sel + 1) % NC;
        outstanding.push_back('{sel, task_size_i});
      end
    end
    if (fb_ok) begin
      m_her[fc]--;
      m_bytes[fc] += fr;
    end
  endtask

  task automatic drive(input bit tv, input logic [31:0] ts, input int th, input bit dr,
                       input bit fv, input int fc, input logic [31:0] fs);
    task_valid_i = tv; task_size_i = ts; task_home_i = 2'(th); disp_ready_i = dr;
    fb_valid_i = fv; fb_cluster_i = 2'(fc); fb_size_i = fs;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] ts, input int th);
    drive(1, ts, th, 1, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    task_valid_i = 0; task_size_i = 0; task_home_i = 0; disp_ready_i = 0;
    fb_valid_i = 0; fb_cluster_i = 0; fb_size_i = 0;
    rst_ni = 0;
    for (int c = 0; c < NC; c++) begin m_her[c] = 0; m_bytes[c] = L1; m_stat[c] = 0; end
    m_rr = 0; m_valid = 0; m_cl = 0; m_sz = 0; m_err = 0;
    outstanding.delete();
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0; task_valid_i = 0; task_size_i = 0; task_home_i = 0;
    disp_ready_i = 0; fb_valid_i = 0; fb_cluster_i = 0; fb_size_i = 0;
    #2;
    checks++;
    if (task_ready_o !== 1'b0 || disp_valid_o !== 1'b0 || disp_cluster_o !== 2'd0 ||
        disp_size_o !== 32'd0 || err_o !== 1'b0 || stat_dispatch_o !== 128'd0) begin
      failures++;
      $display("FAIL reset_state ready=%b valid=%b cl=%0d sz=%0d err=%b stat=%h (want all 0)",
               task_ready_o, disp_valid_o, disp_cluster_o, disp_size_o, err_o, stat_dispatch_o);
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b1 || fb_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready ready=%b fb_ready=%b want 1/1", task_ready_o, fb_ready_o);
    end
    drive(1, 300, 1, 0, 0, 0, 0);
    tick();
    drive(1, 300, 1, 0, 0, 0, 0);
    rst_ni = 0;
    #1;
    checks++;
    if (disp_valid_o !== 1'b0 || task_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop valid=%b ready=%b want 0/0", disp_valid_o, task_ready_o);
    end
    do_reset();
    send(512, 1);
    checks++;
    if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd1 || disp_size_o !== 32'd512) begin
      failures++;
      $display("FAIL reset_credits valid=%b cl=%0d sz=%0d want 1/1/512",
               disp_valid_o, disp_cluster_o, disp_size_o);
    end
  endtask

  task automatic test_home_dispatch();
    do_reset();
    drive(1, 100, 2, 1, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b1) begin
      failures++; $display("FAIL home_ready got=%b want=1", task_ready_o);
    end
    tick();
    checks++;
    if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd2 || disp_size_o !== 32'd100) begin
      failures++;
      $display("FAIL home_disp valid=%b cl=%0d sz=%0d want 1/2/100", disp_valid_o, disp_cluster_o, disp_size_o);
    end
    send(384, 2);
    checks++;
    if (disp_cluster_o !== 2'd2) begin
      failures++; $display("FAIL home_bytes384 cl=%0d want 2", disp_cluster_o);
    end
    send(1, 2);
    checks++;
    if (disp_cluster_o !== 2'd0) begin
      failures++; $display("FAIL home_rr_kept cl=%0d want 0", disp_cluster_o);
    end
  endtask

  task automatic test_fallback();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(128, 1);
      checks++;
      if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd1) begin
        failures++; $display("FAIL fill_c1[%0d] valid=%b cl=%0d want 1/1", i, disp_valid_o, disp_cluster_o);
      end
    end
    send(1, 1);
    checks++;
    if (disp_cluster_o !== 2'd0) begin
      failures++; $display("FAIL fallback_first cl=%0d want 0", disp_cluster_o);
    end
    send(1, 1);
    checks++;
    if (disp_cluster_o !== 2'd2) begin
      failures++; $display("FAIL fallback_rr_advanced cl=%0d want 2", disp_cluster_o);
    end
  endtask

  task automatic test_her_limit();
    do_reset();
    for (int i = 0; i < NC * NH; i++) begin
      send(0, 0);
      checks++;
      if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'(m_cl)) begin
        failures++; $display("FAIL her_fill[%0d] valid=%b cl=%0d want 1/%0d", i, disp_valid_o, disp_cluster_o, m_cl);
      end
    end
    drive(1, 0, 0, 1, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b0) begin
      failures++; $display("FAIL her_full_ready got=%b want=0", task_ready_o);
    end
    tick();
    drive(0, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b1) begin
      failures++; $display("FAIL her_credit_ready got=%b want=1", task_ready_o);
    end
    tick();
    checks++;
    if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd1) begin
      failures++; $display("FAIL her_credit_target valid=%b cl=%0d want 1/1", disp_valid_o, disp_cluster_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(200, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 50, 3, 0, 0, 0, 0);
      checks++;
      if (task_ready_o !== 1'b0) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b want=0", i, task_ready_o);
      end
      tick();
      checks++;
      if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd1 || disp_size_o !== 32'd200) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%b cl=%0d sz=%0d want 1/1/200", i, disp_valid_o, disp_cluster_o, disp_size_o);
      end
    end
    drive(1, 50, 3, 1, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b want=1", task_ready_o);
    end
    tick();
    checks++;
    if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd3 || disp_size_o !== 32'd50) begin
      failures++;
      $display("FAIL bp_next valid=%b cl=%0d sz=%0d want 1/3/50", disp_valid_o, disp_cluster_o, disp_size_o);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send(64, 0);
    drive(1, 64, 0, 1, 1, 0, 64);
    tick();
    send(448, 0);
    checks++;
    if (disp_cluster_o !== 2'd0 || err_o !== 1'b0) begin
      failures++; $display("FAIL net_credit cl=%0d err=%b want 0/0", disp_cluster_o, err_o);
    end
    send(64, 0);
    checks++;
    if (disp_cluster_o !== 2'd1) begin
      failures++; $display("FAIL net_exhausted cl=%0d want 1", disp_cluster_o);
    end
    drive(1, 600, 2, 1, 0, 0, 0);
    checks++;
    if (task_ready_o !== 1'b1) begin
      failures++; $display("FAIL oversize_ready got=%b want=1", task_ready_o);
    end
    tick();
    checks++;
    if (disp_valid_o !== 1'b0 || err_o !== 1'b1) begin
      failures++; $display("FAIL oversize_drop valid=%b err=%b want 0/1", disp_valid_o, err_o);
    end
    do_reset();
    drive(0, 0, 0, 1, 1, 2, 64);
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL fb_idle_err got=%b want=1", err_o);
    end
    send(512, 2);
    checks++;
    if (disp_valid_o !== 1'b1 || disp_cluster_o !== 2'd2) begin
      failures++; $display("FAIL fb_idle_unchanged valid=%b cl=%0d want 1/2", disp_valid_o, disp_cluster_o);
    end
    send(1, 2);
    checks++;
    if (disp_cluster_o !== 2'd0) begin
      failures++; $display("FAIL fb_idle_no_gain cl=%0d want 0", disp_cluster_o);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp3;
`ifdef CLUSTER_DISPATCH_STATS_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) send(10, 3);
    checks++;
    if (stat_dispatch_o[127:96] !== exp3 || stat_dispatch_o[95:0] !== 96'd0) begin
      failures++; $display("FAIL stats_c3 got=%h want c3=%0d others 0", stat_dispatch_o, exp3);
    end
  endtask

  task automatic test_random();
    bit tv, dr, fv;
    logic [31:0] ts, fs;
    int th, fc, idx;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      tv = $urandom_range(0, 3) != 0;
      dr = $urandom_range(0, 3) != 0;
      th = $urandom_range(0, NC - 1);
      case ($urandom_range(0, 31))
        0:       ts = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
        1, 2:    ts = 32'($urandom_range(513, 1000));
        default: ts = 32'($urandom_range(0, 300));
      endcase
      fv = 0; fc = 0; fs = 0;
      if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, outstanding.size() - 1);
        fv = 1; fc = outstanding[idx].cl; fs = outstanding[idx].sz;
        outstanding.delete(idx);
      end else if ($urandom_range(0, 63) == 0) begin
        fv = 1; fc = $urandom_range(0, NC - 1); fs = 32'($urandom_range(0, 600));
      end
      drive(tv, ts, th, dr, fv, fc, fs);
      checks++;
      if (task_ready_o !== m_ready()) begin
        failures++; $display("FAIL rand_ready[%0d] got=%b want=%b", n, task_ready_o, m_ready());
      end
      tick();
      checks++;
      if (disp_valid_o !== m_valid || disp_cluster_o !== 2'(m_cl) || disp_size_o !== m_sz ||
          err_o !== m_err || stat_dispatch_o !== exp_stat()) begin
        failures++;
        $display("FAIL rand_out[%0d] valid=%b/%b cl=%0d/%0d sz=%0d/%0d err=%b/%b stat=%h/%h", n,
                 disp_valid_o, m_valid, disp_cluster_o, m_cl, disp_size_o, m_sz, err_o, m_err,
                 stat_dispatch_o, exp_stat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_home_dispatch();
    test_fallback();
    test_her_limit();
    test_backpressure();
    test_errors();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
